// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control logic of the 5-stage MIPS core.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      MD_BUSY = 2'd2
   } state_t;

   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/load_use_cmp.sv
// Combinational load-use compare: a load in EX writes a register the ID instruction reads.
module load_use_cmp
   import pipe_ctrl_pkg::*;
(
   input  logic       memread,
   input  logic [4:0] ld_rt,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       uses_rt,
   output logic       hazard
);

   // $zero is never a real dependency, so a load targeting it cannot stall.
   assign hazard = memread && (ld_rt != REG_ZERO) &&
                   ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: PC and IF/ID enables, flushes, ID/EX bubbles, mult/div
// occupancy tracking, boot clean-out and a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rt,
   input  logic             ex_branch_taken,
   input  logic             id_md_start,
   input  logic             id_md_read,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int MD_W = $clog2(MD_LAT + 1);

   state_t          state, state_nxt;
   logic [MD_W-1:0] md_cnt, md_cnt_nxt;
   logic            load_use;
   logic            md_stall;
   logic            stall_inc;

   load_use_cmp u_load_use_cmp (
      .memread (idex_memread),
      .ld_rt   (idex_rt),
      .rs      (id_rs),
      .rt      (id_rt),
      .uses_rt (id_uses_rt),
      .hazard  (load_use)
   );

   assign md_stall = (state == MD_BUSY) && (id_md_start || id_md_read);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BOOT;
         md_cnt    <= '0;
         stall_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
         if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // Outputs follow rst > BOOT > flush > stall > normal.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall_inc   = 1'b0;
      md_busy     = (state == MD_BUSY) && !rst;
      if (rst || (state == BOOT)) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use || md_stall) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
         stall_inc   = 1'b1;
      end
   end

   // A flush does not abort an issued mult/div; it only blocks a new one from issuing.
   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (id_md_start && !ex_branch_taken && !load_use) begin
               state_nxt  = MD_BUSY;
               md_cnt_nxt = MD_W'(MD_LAT);
            end
         end
         MD_BUSY: begin
            md_cnt_nxt = md_cnt - 1'b1;
            if (md_cnt == MD_W'(1))
               state_nxt = RUN;
         end
         default: state_nxt = BOOT;
      endcase
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with MD_LAT=4 and a 4-bit stall counter.
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int CNT_W  = 4;

   // Output vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy}
   localparam logic [4:0] V_BOOT     = 5'b00110;
   localparam logic [4:0] V_NORM     = 5'b11000;
   localparam logic [4:0] V_NORM_MD  = 5'b11001;
   localparam logic [4:0] V_STALL    = 5'b00010;
   localparam logic [4:0] V_STALL_MD = 5'b00011;
   localparam logic [4:0] V_FLUSH    = 5'b11110;
   localparam logic [4:0] V_FLUSH_MD = 5'b11111;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs, id_rt, idex_rt;
   logic             id_uses_rt, idex_memread, ex_branch_taken, id_md_start, id_md_read;
   logic             pc_en, ifid_en, ifid_flush, idex_bubble, md_busy;
   logic [CNT_W-1:0] stall_cnt;
   logic [4:0]       outs;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign outs = {pc_en, ifid_en, ifid_flush, idex_bubble, md_busy};

   pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .idex_memread    (idex_memread),
      .idex_rt         (idex_rt),
      .ex_branch_taken (ex_branch_taken),
      .id_md_start     (id_md_start),
      .id_md_read      (id_md_read),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_bubble     (idex_bubble),
      .md_busy         (md_busy),
      .stall_cnt       (stall_cnt)
   );

   task automatic clr_inputs;
      id_rs           = 5'd0;
      id_rt           = 5'd0;
      id_uses_rt      = 1'b0;
      idex_memread    = 1'b0;
      idex_rt         = 5'd0;
      ex_branch_taken = 1'b0;
      id_md_start     = 1'b0;
      id_md_read      = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      clr_inputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== V_BOOT || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_hold cyc%0d outs=%b cnt=%0d expected outs=%b cnt=0", i, outs, stall_cnt, V_BOOT);
         end
         step();
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== V_BOOT) begin
         failures++;
         $display("FAIL boot_cycle outs=%b expected %b", outs, V_BOOT);
      end
      step();
      @(negedge clk);
      checks++;
      if (outs !== V_NORM || stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL first_run outs=%b cnt=%0d expected outs=%b cnt=0", outs, stall_cnt, V_NORM);
      end
      step();
   endtask

   task automatic test_load_use;
      idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
      @(negedge clk);
      checks++;
      if (outs !== V_STALL) begin
         failures++;
         $display("FAIL load_use_rs outs=%b expected %b", outs, V_STALL);
      end
      step();
      clr_inputs();
      @(negedge clk);
      checks++;
      if (outs !== V_NORM || stall_cnt !== 4'd1) begin
         failures++;
         $display("FAIL load_use_release outs=%b cnt=%0d expected outs=%b cnt=1", outs, stall_cnt, V_NORM);
      end
      step();
      idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
      @(negedge clk);
      checks++;
      if (outs !== V_NORM) begin
         failures++;
         $display("FAIL load_use_zero outs=%b expected %b", outs, V_NORM);
      end
      step();
      idex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== V_STALL || stall_cnt !== 4'd1) begin
         failures++;
         $display("FAIL load_use_rt outs=%b cnt=%0d expected outs=%b cnt=1", outs, stall_cnt, V_STALL);
      end
      step();
      id_uses_rt = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== V_NORM || stall_cnt !== 4'd2) begin
         failures++;
         $display("FAIL load_use_rt_unused outs=%b cnt=%0d expected outs=%b cnt=2", outs, stall_cnt, V_NORM);
      end
      step();
      clr_inputs();
   endtask

   task automatic test_md_read_stall;
      id_md_start = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== V_NORM) begin
         failures++;
         $display("FAIL md_accept outs=%b expected %b", outs, V_NORM);
      end
      step();
      id_md_start = 1'b0;
      id_md_read  = 1'b1;
      for (int i = 0; i < MD_LAT; i++) begin
         // Overlap a load-use with the first busy cycle: still one counted stall.
         if (i == 0) begin
            idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd9;
         end else begin
            idex_memread = 1'b0; idex_rt = 5'd0; id_rs = 5'd0;
         end
         @(negedge clk);
         checks++;
         if (outs !== V_STALL_MD) begin
            failures++;
            $display("FAIL md_read_stall cyc%0d outs=%b expected %b", i, outs, V_STALL_MD);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (outs !== V_NORM || stall_cnt !== 4'd6) begin
         failures++;
         $display("FAIL md_read_proceed outs=%b cnt=%0d expected outs=%b cnt=6", outs, stall_cnt, V_NORM);
      end
      step();
      clr_inputs();
   endtask

   task automatic test_back_to_back;
      id_md_start = 1'b1;
      step();
      for (int i = 0; i < MD_LAT; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== V_STALL_MD) begin
            failures++;
            $display("FAIL b2b_stall cyc%0d outs=%b expected %b", i, outs, V_STALL_MD);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (outs !== V_NORM) begin
         failures++;
         $display("FAIL b2b_second_accept outs=%b expected %b", outs, V_NORM);
      end
      step();
      id_md_start = 1'b0;
      for (int i = 0; i < MD_LAT; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== V_NORM_MD) begin
            failures++;
            $display("FAIL b2b_second_busy cyc%0d outs=%b expected %b", i, outs, V_NORM_MD);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (outs !== V_NORM || stall_cnt !== 4'd10) begin
         failures++;
         $display("FAIL b2b_done outs=%b cnt=%0d expected outs=%b cnt=10", outs, stall_cnt, V_NORM);
      end
      step();
   endtask

   task automatic test_flush;
      ex_branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
      @(negedge clk);
      checks++;
      if (outs !== V_FLUSH) begin
         failures++;
         $display("FAIL flush_over_load_use outs=%b expected %b", outs, V_FLUSH);
      end
      step();
      clr_inputs();
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'd10) begin
         failures++;
         $display("FAIL flush_not_counted cnt=%0d expected 10", stall_cnt);
      end
      step();
      ex_branch_taken = 1'b1; id_md_start = 1'b1;
      step();
      clr_inputs();
      @(negedge clk);
      checks++;
      if (outs !== V_NORM) begin
         failures++;
         $display("FAIL flush_md_rejected outs=%b expected %b", outs, V_NORM);
      end
      id_md_start = 1'b1;
      step();
      id_md_start = 1'b0;
      ex_branch_taken = 1'b1;
      @(negedge clk);
      checks++;
      if (outs !== V_FLUSH_MD) begin
         failures++;
         $display("FAIL flush_in_md outs=%b expected %b", outs, V_FLUSH_MD);
      end
      step();
      ex_branch_taken = 1'b0;
      for (int i = 1; i < MD_LAT; i++) begin
         @(negedge clk);
         checks++;
         if (outs !== V_NORM_MD) begin
            failures++;
            $display("FAIL md_survives_flush cyc%0d outs=%b expected %b", i, outs, V_NORM_MD);
         end
         step();
      end
      @(negedge clk);
      checks++;
      if (outs !== V_NORM) begin
         failures++;
         $display("FAIL md_after_flush_done outs=%b expected %b", outs, V_NORM);
      end
      step();
   endtask

   task automatic test_rst_md;
      id_md_start = 1'b1;
      step();
      id_md_start = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== V_NORM_MD) begin
         failures++;
         $display("FAIL rst_md_busy1 outs=%b expected %b", outs, V_NORM_MD);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (outs !== V_BOOT || stall_cnt !== 4'd0) begin
         failures++;
         $display("FAIL rst_md_abort outs=%b cnt=%0d expected outs=%b cnt=0", outs, stall_cnt, V_BOOT);
      end
      step();
      @(negedge clk);
      checks++;
      if (outs !== V_NORM) begin
         failures++;
         $display("FAIL rst_md_rerun outs=%b expected %b", outs, V_NORM);
      end
      step();
   endtask

   task automatic test_saturation;
      logic [CNT_W-1:0] exp_cnt;
      idex_memread = 1'b1; idex_rt = 5'd12; id_rs = 5'd12;
      for (int i = 0; i < 18; i++) begin
         exp_cnt = (i > 15) ? 4'd15 : 4'(i);
         @(negedge clk);
         checks++;
         if (outs !== V_STALL || stall_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL sat cyc%0d outs=%b cnt=%0d expected outs=%b cnt=%0d", i, outs, stall_cnt, V_STALL, exp_cnt);
         end
         step();
      end
      clr_inputs();
      @(negedge clk);
      checks++;
      if (stall_cnt !== 4'd15) begin
         failures++;
         $display("FAIL sat_hold cnt=%0d expected 15", stall_cnt);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_md_read_stall();
      test_back_to_back();
      test_flush();
      test_rst_md();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core. Drives the enable and flush controls of the PC register and the IF/ID latch, and the bubble-insert control of the ID/EX latch. Resolves load-use data hazards, taken-branch redirects and multi-cycle mult/div structural hazards. Also sequences a one-cycle pipeline clean-out after reset and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MD_LAT, 4, cycles the mult/div unit stays busy after an op issues; legal range ≥1
- CNT_W, 16, width of the stall counter
- Clock: `clk`. Reset: `rst`, synchronous, active-high.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- idex_memread  in  1  instruction in EX is a load
- idex_rt  in  5  destination register of the load in EX
- ex_branch_taken  in  1  branch or jump resolved taken in EX
- id_md_start  in  1  ID holds mult/multu/div/divu
- id_md_read  in  1  ID holds mfhi/mflo
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID latch load enable
- ifid_flush  out  1  IF/ID latch loads a NOP
- idex_bubble  out  1  ID/EX latch loads a NOP
- md_busy  out  1  mult/div unit occupied
- stall_cnt  out  CNT_W  count of stall cycles, saturating

## Operation
- FSM states: BOOT, RUN, MD_BUSY. Registers: state, md_cnt (width clog2(MD_LAT+1)), stall_cnt.
- Control outputs are combinational from the state and current inputs. md_busy is 1 exactly when state is MD_BUSY.
- Priority order: rst > BOOT > flush > load-use > md stall > normal.
- rst or BOOT: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, md_busy=0.
  - rst forces state to BOOT and clears md_cnt and stall_cnt.
  - BOOT always moves to RUN on the next edge.
- flush: ex_branch_taken=1 gives pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1. An md op in ID is flushed and is not accepted.
- load-use: idex_memread and idex_rt≠0 and (idex_rt==id_rs or (id_uses_rt and idex_rt==id_rt)). Outputs pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=1.
- md stall: state MD_BUSY and (id_md_start or id_md_read). Same outputs as load-use.
- normal: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- md accept: in RUN, id_md_start=1 and no flush and no load-use. Loads md_cnt←MD_LAT and moves to MD_BUSY.
- MD_BUSY:
  - md_cnt decrements every cycle.
  - When md_cnt==1, the next state is RUN.
  - A flush during MD_BUSY does not abort it; the issued op completes.
- stall_cnt increments on every load-use or md-stall cycle. It holds at 2^CNT_W−1. BOOT and flush cycles are not counted.

## Timing
- Reset values: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, md_busy=0, stall_cnt=0.
- First edge with rst=0 leaves BOOT; pc_en=1 from the following cycle.
- Hazard outputs have zero latency: same cycle as the inputs.
- Load-use stall lasts exactly 1 cycle, because the bubble clears idex_memread.
- md_busy is high for exactly MD_LAT cycles, starting the cycle after acceptance.
- A new id_md_start in the cycle MD_BUSY→RUN is stalled that cycle and accepted the next.
- Load-use and MD_BUSY in the same cycle: one stall cycle, counted once.
- rst mid-MD_BUSY aborts to BOOT; md_busy=0 the next cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum {BOOT, RUN, MD_BUSY}
  - REG_ZERO = 5'd0
  - localparam for the NOP encoding (32'h00000000) used by the latches
- One sub-module, `load_use_cmp`: purely combinational load-use compare, reused later by the forwarding unit.

## Test plan
- rst high 3 cycles, then low → outputs at reset values; one BOOT cycle; pc_en=1 on cycle 2 after release; stall_cnt=0.
- idex_memread=1, idex_rt=5, id_rs=5 → pc_en=0, ifid_en=0, idex_bubble=1 for 1 cycle; stall_cnt=1. Repeat with idex_rt=0 → no stall.
- id_md_start with MD_LAT=4 → md_busy high 4 cycles. id_md_read held in ID → stalls 4 cycles, stall_cnt=4, proceeds on cycle 5.
- ex_branch_taken together with a load-use condition → flush wins: pc_en=1, ifid_flush=1, idex_bubble=1, stall_cnt unchanged.
- rst asserted in the 2nd md_busy cycle → md_busy=0 and state BOOT next cycle; stall_cnt=0.
- Stall counter preloaded near saturation via forced stalls with CNT_W=4 → holds at 15 after 16+ stalls.
